// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: imem request/response channel and the decode handoff of the fetch stage.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the next PC and runs one-outstanding imem fetches into decode.
module fetch_sequencer #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_out,
    output logic [31:0]       pc_in,
    fetch_sequencer_if.master bus,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic              misalign_fault,
    output logic [31:0]       fault_addr
);
    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        misalign_fault_q, misalign_fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        misaligned;

    always_comb begin
        misaligned       = redirect_valid & (redirect_target[1:0] != 2'b00);
        state_d          = state_q;
        instr_valid_d    = instr_valid_q;
        instr_d          = instr_q;
        instr_pc_d       = instr_pc_q;
        misalign_fault_d = misaligned;
        fault_addr_d     = misaligned ? redirect_target : fault_addr_q;
        pc_in            = pc_out;
        case (state_q)
            S_REQ:  state_d = bus.imem_gnt ? S_WAIT : S_REQ;
            S_WAIT: if (bus.imem_rvalid) begin
                state_d       = S_HOLD;
                instr_valid_d = 1'b1;
                instr_d       = bus.imem_rdata;
                instr_pc_d    = pc_out;
            end
            S_HOLD: if (bus.instr_ready) begin
                state_d       = S_REQ;
                instr_valid_d = 1'b0;
                pc_in         = pc_out + 32'd4;
            end
            default: state_d = bus.imem_rvalid ? S_REQ : S_DRAIN;
        endcase
        // A redirect squashes whatever is in flight; an accepted but unanswered fetch must be drained.
        if (redirect_valid) begin
            pc_in         = misaligned ? TRAP_VECTOR : redirect_target;
            instr_valid_d = 1'b0;
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            case (state_q)
                S_REQ:           state_d = bus.imem_gnt ? S_DRAIN : S_REQ;
                S_WAIT, S_DRAIN: state_d = bus.imem_rvalid ? S_REQ : S_DRAIN;
                default:         state_d = S_REQ;
            endcase
        end
        if (reset) pc_in = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_REQ;
            instr_valid_q    <= 1'b0;
            instr_q          <= 32'h0;
            instr_pc_q       <= 32'h0;
            misalign_fault_q <= 1'b0;
            fault_addr_q     <= 32'h0;
        end else begin
            state_q          <= state_d;
            instr_valid_q    <= instr_valid_d;
            instr_q          <= instr_d;
            instr_pc_q       <= instr_pc_d;
            misalign_fault_q <= misalign_fault_d;
            fault_addr_q     <= fault_addr_d;
        end
    end

    assign bus.imem_req    = !reset && (state_q == S_REQ);
    assign bus.imem_addr   = pc_out;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign misalign_fault  = misalign_fault_q;
    assign fault_addr      = fault_addr_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: PC register and imem models around fetch_sequencer; directed steps then random traffic
// checked against an instruction-stream model (next expected PC, last faulting target).
module tb_fetch_sequencer;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] pc_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misalign_fault;
    logic [31:0] fault_addr;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.TRAP_VECTOR(TRAP)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_out          (pc_out),
        .pc_in           (pc_in),
        .bus             (bus),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misalign_fault  (misalign_fault),
        .fault_addr      (fault_addr)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic        pend;
    int          cnt;
    int          lat;
    logic [31:0] paddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: PC register captures pc_in, imem answers an accepted request after lat cycles.
    task automatic tick();
        logic        acc, fire, rst_s;
        logic [31:0] npc, a;
        acc   = bus.imem_req & bus.imem_gnt;
        fire  = bus.imem_rvalid;
        npc   = pc_in;
        a     = bus.imem_addr;
        rst_s = reset;
        @(posedge clk);
        #1;
        pc_out = rst_s ? 32'h0 : npc;
        if (fire) pend = 1'b0;
        else if (pend && cnt != 0) cnt--;
        if (acc) begin
            pend  = 1'b1;
            paddr = a;
            cnt   = lat - 1;
        end
        if (rst_s) pend = 1'b0;
        bus.imem_rvalid = pend && cnt == 0;
        bus.imem_rdata  = bus.imem_rvalid ? mem_word(paddr) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic fetch_expect(input logic [31:0] a);
        chk("fetch_req", bus.imem_req, 1'b1);
        chk("fetch_addr", bus.imem_addr, a);
        tick();
        chk("fetch_wait_valid", bus.instr_valid, 1'b0);
        tick();
        chk("fetch_valid", bus.instr_valid, 1'b1);
        chk("fetch_instr_pc", bus.instr_pc, a);
        chk("fetch_instr", bus.instr, mem_word(a));
    endtask

    initial begin
        logic [31:0] exp_pc, exp_fault;
        logic        exp_mis, prev_hold, mis;
        int          presented;
        reset = 1'b1;
        pc_out = 32'h0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b1;
        pend = 1'b0;
        cnt = 0;
        lat = 1;
        paddr = 32'h0;
        tick();
        tick();
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_pc_in", pc_in, 32'h0);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_fault", misalign_fault, 1'b0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        reset = 1'b0;
        #1;
        fetch_expect(32'h0);
        chk("seq_pc_in", pc_in, 32'h4);
        tick();
        bus.imem_gnt = 1'b0;
        repeat (4) begin
            chk("stall_req", bus.imem_req, 1'b1);
            chk("stall_addr", bus.imem_addr, 32'h4);
            chk("stall_valid", bus.instr_valid, 1'b0);
            tick();
        end
        bus.imem_gnt = 1'b1;
        #1;
        fetch_expect(32'h4);
        tick();
        fetch_expect(32'h8);
        tick();
        lat = 3;
        chk("wait_req", bus.imem_req, 1'b1);
        tick();
        lat = 1;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        #1;
        chk("wait_redir_pc_in", pc_in, 32'h40);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("drain_req", bus.imem_req, 1'b0);
        chk("drain_addr", bus.imem_addr, 32'h40);
        tick();
        chk("drain_rvalid_req", bus.imem_req, 1'b0);
        chk("drain_rvalid_valid", bus.instr_valid, 1'b0);
        tick();
        chk("drain_done_valid", bus.instr_valid, 1'b0);
        fetch_expect(32'h40);
        tick();
        bus.instr_ready = 1'b0;
        #1;
        fetch_expect(32'h44);
        repeat (5) begin
            tick();
            chk("hold_valid", bus.instr_valid, 1'b1);
            chk("hold_instr_pc", bus.instr_pc, 32'h44);
            chk("hold_instr", bus.instr, mem_word(32'h44));
            chk("hold_req", bus.imem_req, 1'b0);
            chk("hold_pc_in", pc_in, 32'h44);
        end
        bus.instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h82;
        #1;
        chk("mis_pc_in", pc_in, TRAP);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("mis_pulse", misalign_fault, 1'b1);
        chk("mis_fault_addr", fault_addr, 32'h82);
        chk("mis_valid", bus.instr_valid, 1'b0);
        fetch_expect(TRAP);
        chk("mis_pulse_end", misalign_fault, 1'b0);
        chk("mis_fault_hold", fault_addr, 32'h82);
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        #1;
        chk("wrap_redir_pc_in", pc_in, 32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        #1;
        fetch_expect(32'hFFFF_FFFC);
        chk("wrap_pc_in", pc_in, 32'h0);
        tick();
        fetch_expect(32'h0);

        exp_pc = 32'h0;
        exp_fault = 32'h82;
        exp_mis = 1'b0;
        prev_hold = 1'b0;
        presented = 0;
        for (int i = 0; i < 3000; i++) begin
            bus.imem_gnt = $urandom_range(0, 3) != 0;
            bus.instr_ready = $urandom_range(0, 2) != 0;
            lat = $urandom_range(1, 3);
            redirect_valid = $urandom_range(0, 11) == 0;
            redirect_target = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
            #1;
            mis = redirect_valid && redirect_target[1:0] != 2'b00;
            chk("rnd_fault", misalign_fault, exp_mis);
            chk("rnd_fault_addr", fault_addr, exp_fault);
            chk("rnd_req_outstanding", bus.imem_req & pend, 1'b0);
            if (prev_hold) chk("rnd_hold_valid", bus.instr_valid, 1'b1);
            if (bus.instr_valid) begin
                chk("rnd_instr_pc", bus.instr_pc, exp_pc);
                chk("rnd_instr", bus.instr, mem_word(exp_pc));
            end
            if (redirect_valid) chk("rnd_redir_pc_in", pc_in, mis ? TRAP : redirect_target);
            exp_mis = mis;
            if (mis) exp_fault = redirect_target;
            prev_hold = bus.instr_valid && !bus.instr_ready && !redirect_valid;
            if (bus.instr_valid && bus.instr_ready) presented++;
            if (redirect_valid) exp_pc = mis ? TRAP : redirect_target;
            else if (bus.instr_valid && bus.instr_ready) exp_pc = exp_pc + 32'd4;
            tick();
        end
        chk("rnd_progress", presented >= 50, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
